hyperbus_clk_ca_rx: RTL and testbench



---
 rtl/hyperbus_clk_ca_rx_pkg.sv | 35 +++
 rtl/hyperbus_clk_ca_rx_assembler.sv | 54 +++++
 rtl/hyperbus_clk_ca_rx.sv | 81 ++++++++
 tb/tb_hyperbus_clk_ca_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_clk_ca_rx_pkg.sv
// Shared HyperBus constants: command/address bit positions, CA word type and
// quadrature phase decode for the clk_i/4 clock generator.
package hyperbus_pkg;

  localparam int unsigned CA_RW = 47;
  localparam int unsigned CA_AS = 46;
  localparam int unsigned CA_BT = 45;

  typedef logic [47:0] cmd_addr_t;

  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_e;

  // Bit order {clk270, clk180, clk90, clk0}
  localparam logic [3:0] PH_DEC_0 = 4'b1001;
  localparam logic [3:0] PH_DEC_1 = 4'b0011;
  localparam logic [3:0] PH_DEC_2 = 4'b0110;
  localparam logic [3:0] PH_DEC_3 = 4'b1100;

  function automatic logic [3:0] phase_decode(input phase_e p);
    logic [3:0] d;
    unique case (p)
      PH_0:    d = PH_DEC_0;
      PH_1:    d = PH_DEC_1;
      PH_2:    d = PH_DEC_2;
      default: d = PH_DEC_3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hyperbus_clk_ca_rx_assembler.sv
// RX byte assembler: registers RWDS/DQ from the pad, detects RWDS edges and
// pairs the rising-edge byte with the falling-edge byte into a half-word.
module hyperbus_rx_assembler
  import hyperbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rwds,
  input  logic [7:0]  dq,
  input  logic        enable,
  output logic [15:0] data,
  output logic        data_valid
);

  logic       rwds_q;
  logic       rwds_qq;
  logic [7:0] dq_q;
  logic [7:0] hi_byte;
  logic       hi_pending;
  logic       rise;
  logic       fall;

  assign rise = rwds_q & ~rwds_qq;
  assign fall = ~rwds_q & rwds_qq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rwds_q     <= 1'b0;
      rwds_qq    <= 1'b0;
      dq_q       <= '0;
      hi_byte    <= '0;
      hi_pending <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      rwds_q     <= rwds;
      rwds_qq    <= rwds_q;
      dq_q       <= dq;
      data_valid <= 1'b0;
      // Dropping enable abandons any half-captured word.
      if (!enable) begin
        hi_pending <= 1'b0;
      end else if (rise) begin
        hi_byte    <= dq_q;
        hi_pending <= 1'b1;
      end else if (fall && hi_pending) begin
        data       <= {hi_byte, dq_q};
        data_valid <= 1'b1;
        hi_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hyperbus_clk_ca_rx.sv
// HyperBus clock/CA/RX slice: quadrature clk_i/4 phase generator, CA word
// builder and RX assembler. Define HYPERBUS_CA_REG_EN to register cmd_addr_o.
module hyperbus_clk_ca_rx
  import hyperbus_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        clk0_o,
  output logic        clk90_o,
  output logic        clk180_o,
  output logic        clk270_o,
  input  logic        rw_i,
  input  logic        address_space_i,
  input  logic        burst_type_i,
  input  logic [31:0] address_i,
  output logic [47:0] cmd_addr_o,
  input  logic        hyper_rwds_i_d,
  input  logic [7:0]  hyper_dq_i,
  input  logic        enable,
  output logic [15:0] data_o,
  output logic        data_valid_o
);

  phase_e    phase;
  phase_e    phase_next;
  logic [3:0] phase_dec;
  cmd_addr_t ca_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase <= PH_0;
    end else begin
      phase <= phase_next;
    end
  end

  always_comb begin
    phase_next = phase_e'(phase + 2'd1);
    phase_dec  = phase_decode(phase);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      {clk270_o, clk180_o, clk90_o, clk0_o} <= '0;
    end else begin
      {clk270_o, clk180_o, clk90_o, clk0_o} <= phase_dec;
    end
  end

  always_comb begin
    ca_next          = '0;
    ca_next[CA_RW]   = rw_i;
    ca_next[CA_AS]   = address_space_i;
    ca_next[CA_BT]   = burst_type_i;
    ca_next[44:16]   = address_i[31:3];
    ca_next[2:0]     = address_i[2:0];
  end

`ifdef HYPERBUS_CA_REG_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cmd_addr_o <= '0;
    end else begin
      cmd_addr_o <= ca_next;
    end
  end
`else
  assign cmd_addr_o = ca_next;
`endif

  hyperbus_rx_assembler u_rx (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .rwds       (hyper_rwds_i_d),
    .dq         (hyper_dq_i),
    .enable     (enable),
    .data       (data_o),
    .data_valid (data_valid_o)
  );

endmodule

// File: tb/tb_hyperbus_clk_ca_rx.sv
// Self-checking bench for hyperbus_clk_ca_rx: directed plus randomized RWDS/DQ
// traffic compared against a per-edge reference model of the receive rules.
module tb_hyperbus_clk_ca_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk0, clk90, clk180, clk270;
  logic        rw = 1'b0, aspace = 1'b0, btype = 1'b0;
  logic [31:0] addr = '0;
  logic [47:0] cmd_addr;
  logic        rwds = 1'b0;
  logic [7:0]  dq = '0;
  logic        en = 1'b0;
  logic [15:0] data;
  logic        data_valid;

  always #5 clk = ~clk;

  hyperbus_clk_ca_rx dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clk0_o          (clk0),
    .clk90_o         (clk90),
    .clk180_o        (clk180),
    .clk270_o        (clk270),
    .rw_i            (rw),
    .address_space_i (aspace),
    .burst_type_i    (btype),
    .address_i       (addr),
    .cmd_addr_o      (cmd_addr),
    .hyper_rwds_i_d  (rwds),
    .hyper_dq_i      (dq),
    .enable          (en),
    .data_o          (data),
    .data_valid_o    (data_valid)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: history of sampled pad values plus receive state.
  logic        rw_hist[$];
  logic [7:0]  dq_hist[$];
  logic        m_pending = 1'b0;
  logic [7:0]  m_hi = '0;
  logic [15:0] m_data = '0;
  logic        m_valid = 1'b0;
  int          since_rel = -1;
  int unsigned n_strobes = 0;

  function automatic logic [3:0] exp_phases(input int k);
    logic [3:0] r;
    r = '0;
    if (k >= 0) begin
      for (int n = 0; n < 4; n++) r[n] = (((k + 4 - n) % 4) < 2);
    end
    return r;
  endfunction

  function automatic logic [47:0] exp_ca(input logic r, input logic a, input logic b,
                                         input logic [31:0] ad);
    return {r, a, b, ad[31:3], 13'd0, ad[2:0]};
  endfunction

  task automatic tick();
    logic rst_s, en_s, rw_s, prev1, prev2;
    logic [7:0] dq_s, dq_prev;
    rst_s = rst_n; en_s = en; rw_s = rwds; dq_s = dq;
    @(posedge clk);
    if (!rst_s) begin
      rw_hist.push_back(1'b0);
      dq_hist.push_back(8'h00);
      m_pending = 1'b0; m_hi = '0; m_data = '0; m_valid = 1'b0;
      since_rel = -1;
    end else begin
      prev1   = rw_hist[$];
      prev2   = rw_hist[$-1];
      dq_prev = dq_hist[$];
      m_valid = 1'b0;
      if (!en_s) begin
        m_pending = 1'b0;
      end else if (prev1 && !prev2) begin
        m_hi = dq_prev;
        m_pending = 1'b1;
      end else if (!prev1 && prev2 && m_pending) begin
        m_data = {m_hi, dq_prev};
        m_valid = 1'b1;
        m_pending = 1'b0;
      end
      rw_hist.push_back(rw_s);
      dq_hist.push_back(dq_s);
      since_rel++;
    end
    while (rw_hist.size() > 4) begin
      void'(rw_hist.pop_front());
      void'(dq_hist.pop_front());
    end
    #1;
    if (m_valid) n_strobes++;
    check("phases", {clk270, clk180, clk90, clk0}, exp_phases(since_rel));
    check("valid", data_valid, m_valid);
    check("data", data, m_data);
  endtask

  task automatic seg(input logic r, input logic [7:0] d, input logic e, input int n);
    rwds = r; dq = d; en = e;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int unsigned s0;
    logic lvl;
    rw_hist.push_back(1'b0); rw_hist.push_back(1'b0);
    dq_hist.push_back(8'h00); dq_hist.push_back(8'h00);

    // Reset state, then phase pattern over 12 cycles
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // Command/address word
    rw = 1'b1; aspace = 1'b0; btype = 1'b1; addr = 32'h0000_1235;
    tick();
    check("ca_vec1", cmd_addr, 48'hA000_0246_0005);
    rw = 1'b0; aspace = 1'b1; btype = 1'b0; addr = 32'hFFFF_FFFF;
    tick();
    check("ca_vec2", cmd_addr, 48'h5FFF_FFFF_0007);
    for (int i = 0; i < 16; i++) begin
      rw = 1'($urandom); aspace = 1'($urandom); btype = 1'($urandom); addr = $urandom;
      tick();
      check("ca_rand", cmd_addr, exp_ca(rw, aspace, btype, addr));
    end

    // Basic word capture
    seg(1'b0, 8'h00, 1'b1, 3);
    s0 = n_strobes;
    seg(1'b1, 8'hAB, 1'b1, 2);
    seg(1'b0, 8'hCD, 1'b1, 4);
    check("abcd_data", data, 16'hABCD);
    check("abcd_strobes", n_strobes - s0, 1);

    // Enable dropped between rise and fall
    s0 = n_strobes;
    seg(1'b1, 8'h11, 1'b1, 2);
    seg(1'b1, 8'h11, 1'b0, 1);
    seg(1'b0, 8'h22, 1'b1, 4);
    // Fall with no qualifying preceding rise
    seg(1'b1, 8'h33, 1'b0, 3);
    seg(1'b0, 8'h44, 1'b1, 4);
    check("blocked_data", data, 16'hABCD);
    check("blocked_strobes", n_strobes - s0, 0);

    // Reset mid-word
    seg(1'b1, 8'h55, 1'b1, 2);
    rwds = 1'b0; rst_n = 1'b0;
    tick(); tick();
    check("rst_data", data, 16'h0000);
    rst_n = 1'b1;
    s0 = n_strobes;
    seg(1'b0, 8'h66, 1'b1, 4);
    check("rst_strobes", n_strobes - s0, 0);

    // Randomized in-contract traffic
    lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) begin
        rst_n = 1'b0;
        rwds = 1'b0; lvl = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      lvl = ~lvl;
      seg(lvl, 8'($urandom), ($urandom_range(9) != 0), int'($urandom_range(2, 4)));
    end
    check("rand_strobes_seen", (n_strobes > 20), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
